// File: rtl/ctrl_pkg.sv
// Shared definitions for the alu_reg control sequencer: opcodes, ALU codes,
// FSM states, instruction field positions and the decoded control word.
package ctrl_pkg;

    localparam logic [4:0] SCR_REG_DEF = 5'd27;
    localparam int         K_WIDTH_DEF = 64;

    localparam int OP_MSB  = 31;
    localparam int OP_LSB  = 26;
    localparam int RD_MSB  = 25;
    localparam int RD_LSB  = 21;
    localparam int RN_MSB  = 20;
    localparam int RN_LSB  = 16;
    localparam int RM_MSB  = 15;
    localparam int RM_LSB  = 11;
    localparam int IMM_MSB = 15;
    localparam int IMM_LSB = 0;

    localparam logic [5:0] OP_NOP  = 6'h00;
    localparam logic [5:0] OP_ADD  = 6'h01;
    localparam logic [5:0] OP_SUB  = 6'h02;
    localparam logic [5:0] OP_AND  = 6'h03;
    localparam logic [5:0] OP_ORR  = 6'h04;
    localparam logic [5:0] OP_EOR  = 6'h05;
    localparam logic [5:0] OP_ADDI = 6'h06;
    localparam logic [5:0] OP_SUBI = 6'h07;
    localparam logic [5:0] OP_MOV  = 6'h08;
    localparam logic [5:0] OP_SWP  = 6'h09;
    localparam logic [5:0] OP_CMP  = 6'h0A;
    localparam logic [5:0] OP_LDI  = 6'h0B;

    localparam logic [4:0] FS_AND   = 5'h00;
    localparam logic [4:0] FS_ORR   = 5'h04;
    localparam logic [4:0] FS_ADD   = 5'h08;
    localparam logic [4:0] FS_SUB   = 5'h09;
    localparam logic [4:0] FS_EOR   = 5'h0C;
    localparam logic [4:0] FS_PASSB = 5'h10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXEC,
        ST_SWP1,
        ST_SWP2,
        ST_SWP3,
        ST_DONE
    } state_t;

    // k is carried as the raw immediate; the top zero-extends it to K_WIDTH.
    typedef struct packed {
        logic [4:0]  fs;
        logic [4:0]  addr_r;
        logic [4:0]  addr_a;
        logic [4:0]  addr_b;
        logic [15:0] imm;
        logic        s;
        logic        sd;
        logic        sb;
        logic        c0;
        logic        w;
    } ctrl_word_t;

    function automatic logic [5:0] op_of(input logic [31:0] ins);
        return ins[OP_MSB:OP_LSB];
    endfunction

    function automatic logic [4:0] rd_of(input logic [31:0] ins);
        return ins[RD_MSB:RD_LSB];
    endfunction

    function automatic logic [4:0] rn_of(input logic [31:0] ins);
        return ins[RN_MSB:RN_LSB];
    endfunction

    function automatic logic [4:0] rm_of(input logic [31:0] ins);
        return ins[RM_MSB:RM_LSB];
    endfunction

    function automatic logic [15:0] imm_of(input logic [31:0] ins);
        return ins[IMM_MSB:IMM_LSB];
    endfunction

    // SWP may not name the scratch register, since it would be clobbered mid-swap.
    function automatic logic instr_legal(input logic [31:0] ins, input logic [4:0] scr);
        logic ok;
        ok = (op_of(ins) <= OP_LDI);
        if (op_of(ins) == OP_SWP && (rd_of(ins) == scr || rn_of(ins) == scr)) begin
            ok = 1'b0;
        end
        return ok;
    endfunction

endpackage

// File: rtl/ctrl_sequencer_if.sv
// Instruction handshake plus datapath control/status bundle of the sequencer.
interface ctrl_sequencer_if #(
    parameter int K_WIDTH = 64
);
    logic [31:0]        instr;
    logic               instr_valid;
    logic               instr_ready;
    logic [3:0]         status;
    logic [4:0]         fs;
    logic [4:0]         addrR;
    logic [4:0]         addrA;
    logic [4:0]         addrB;
    logic [K_WIDTH-1:0] k;
    logic               s;
    logic               sd;
    logic               sb;
    logic               c0;
    logic               w;
    logic [3:0]         flags;
    logic               done;
    logic               err;

    modport master (
        output instr, instr_valid, status,
        input  instr_ready, fs, addrR, addrA, addrB, k, s, sd, sb, c0, w, flags, done, err
    );

    modport slave (
        input  instr, instr_valid, status,
        output instr_ready, fs, addrR, addrA, addrB, k, s, sd, sb, c0, w, flags, done, err
    );
endinterface

// File: rtl/ctrl_decode.sv
// Combinational decode of (state, latched instruction) into the datapath control word.
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter logic [4:0] SCR_REG = SCR_REG_DEF
) (
    input  state_t      state,
    input  logic [31:0] ir,
    output ctrl_word_t  cw
);
    logic [5:0] op;
    logic [4:0] rd;
    logic [4:0] rn;
    logic [4:0] rm;

    assign op = op_of(ir);
    assign rd = rd_of(ir);
    assign rn = rn_of(ir);
    assign rm = rm_of(ir);

    always_comb begin
        // NOTE: default every field first so no path through the cases infers a latch.
        cw = '0;
        unique case (state)
            ST_EXEC: begin
                cw.addr_r = rd;
                cw.addr_a = rn;
                cw.addr_b = rm;
                case (op)
                    OP_ADD:  begin cw.fs = FS_ADD; cw.sd = 1'b1; cw.w = 1'b1; end
                    OP_SUB:  begin cw.fs = FS_SUB; cw.c0 = 1'b1; cw.sd = 1'b1; cw.w = 1'b1; end
                    OP_AND:  begin cw.fs = FS_AND; cw.sd = 1'b1; cw.w = 1'b1; end
                    OP_ORR:  begin cw.fs = FS_ORR; cw.sd = 1'b1; cw.w = 1'b1; end
                    OP_EOR:  begin cw.fs = FS_EOR; cw.sd = 1'b1; cw.w = 1'b1; end
                    OP_ADDI: begin
                        cw.fs = FS_ADD; cw.s = 1'b1; cw.imm = imm_of(ir);
                        cw.sd = 1'b1; cw.w = 1'b1;
                    end
                    OP_SUBI: begin
                        cw.fs = FS_SUB; cw.c0 = 1'b1; cw.s = 1'b1; cw.imm = imm_of(ir);
                        cw.sd = 1'b1; cw.w = 1'b1;
                    end
                    OP_MOV:  begin cw.sb = 1'b1; cw.w = 1'b1; end
                    OP_CMP:  begin cw.fs = FS_SUB; cw.c0 = 1'b1; end
                    OP_LDI:  begin
                        cw.fs = FS_PASSB; cw.s = 1'b1; cw.imm = imm_of(ir);
                        cw.sd = 1'b1; cw.w = 1'b1;
                    end
                    default: ;
                endcase
            end
            // Swap rotates through the scratch register: rd -> SCR, rn -> rd, SCR -> rn.
            ST_SWP1: begin cw.addr_b = rd;      cw.addr_r = SCR_REG; cw.sb = 1'b1; cw.w = 1'b1; end
            ST_SWP2: begin cw.addr_b = rn;      cw.addr_r = rd;      cw.sb = 1'b1; cw.w = 1'b1; end
            ST_SWP3: begin cw.addr_b = SCR_REG; cw.addr_r = rn;      cw.sb = 1'b1; cw.w = 1'b1; end
            default: ;
        endcase
    end
endmodule

// File: rtl/ctrl_sequencer.sv
// Multi-cycle control unit: accepts one instruction per handshake and drives the
// alu_reg control word for 1-3 execute cycles, latching ALU flags on CMP.
module ctrl_sequencer
    import ctrl_pkg::*;
#(
    parameter logic [4:0] SCR_REG = SCR_REG_DEF,
    parameter int         K_WIDTH = K_WIDTH_DEF
) (
    input logic            clk,
    input logic            rst,
    ctrl_sequencer_if.slave bus
);
    state_t      state_q, state_d;
    logic [31:0] ir_q, ir_d;
    logic [3:0]  flags_q, flags_d;
    logic        err_q, err_d;
    logic        xfer;
    ctrl_word_t  cw;

    assign xfer = bus.instr_valid && (state_q == ST_IDLE);

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        flags_d = flags_q;
        err_d   = err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (xfer) begin
                    ir_d = bus.instr;
                    if (!instr_legal(bus.instr, SCR_REG)) begin
                        state_d = ST_DONE;
                        err_d   = 1'b1;
                    end else if (op_of(bus.instr) == OP_SWP) begin
                        state_d = ST_SWP1;
                    end else begin
                        state_d = ST_EXEC;
                    end
                end
            end
            ST_EXEC: begin
                state_d = ST_DONE;
                if (op_of(ir_q) == OP_CMP) begin
                    flags_d = bus.status;
                end
            end
            ST_SWP1: state_d = ST_SWP2;
            ST_SWP2: state_d = ST_SWP3;
            ST_SWP3: state_d = ST_DONE;
            ST_DONE: begin
                state_d = ST_IDLE;
                err_d   = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples the pre-edge values.
        if (!rst) begin
            state_q <= ST_IDLE;
            ir_q    <= '0;
            flags_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            flags_q <= flags_d;
            err_q   <= err_d;
        end
    end

    ctrl_decode #(.SCR_REG(SCR_REG)) u_decode (
        .state (state_q),
        .ir    (ir_q),
        .cw    (cw)
    );

    assign bus.fs          = cw.fs;
    assign bus.addrR       = cw.addr_r;
    assign bus.addrA       = cw.addr_a;
    assign bus.addrB       = cw.addr_b;
    assign bus.k           = {{(K_WIDTH-16){1'b0}}, cw.imm};
    assign bus.s           = cw.s;
    assign bus.sd          = cw.sd;
    assign bus.sb          = cw.sb;
    assign bus.c0          = cw.c0;
    assign bus.w           = cw.w;
    assign bus.flags       = flags_q;
    assign bus.instr_ready = (state_q == ST_IDLE);
    assign bus.done        = (state_q == ST_DONE);
    assign bus.err         = (state_q == ST_DONE) && err_q;
endmodule

// File: tb/tb_ctrl_sequencer.sv
// Bench for ctrl_sequencer: a behavioural alu_reg datapath closes the loop, and a
// per-instruction register/flag model checks directed and random instruction streams.
`timescale 1ns/1ps
module tb_ctrl_sequencer;
    import ctrl_pkg::*;

    localparam logic [4:0] SCR = 5'd27;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ctrl_sequencer_if #(.K_WIDTH(64)) ifc ();

    ctrl_sequencer #(.SCR_REG(SCR), .K_WIDTH(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    // Behavioural datapath driven by the control word.
    logic [63:0] dp_r [32];
    logic [63:0] a_val, b_reg, b_mux, b_eff, alu_y;
    logic [64:0] sum;
    logic        v_flag;

    always_comb begin
        a_val  = dp_r[ifc.addrA];
        b_reg  = dp_r[ifc.addrB];
        b_mux  = ifc.s ? ifc.k : b_reg;
        b_eff  = (ifc.fs == FS_SUB) ? ~b_mux : b_mux;
        sum    = {1'b0, a_val} + {1'b0, b_eff} + {64'd0, ifc.c0};
        alu_y  = '0;
        v_flag = 1'b0;
        case (ifc.fs)
            FS_ADD, FS_SUB: begin
                alu_y  = sum[63:0];
                v_flag = (a_val[63] == b_eff[63]) && (alu_y[63] != a_val[63]);
            end
            FS_AND:   alu_y = a_val & b_mux;
            FS_ORR:   alu_y = a_val | b_mux;
            FS_EOR:   alu_y = a_val ^ b_mux;
            FS_PASSB: alu_y = b_mux;
            default:  alu_y = '0;
        endcase
        ifc.status = {v_flag, ((ifc.fs == FS_ADD || ifc.fs == FS_SUB) ? sum[64] : 1'b0),
                      alu_y[63], (alu_y == 64'd0)};
    end

    always @(posedge clk) begin
        if (ifc.w) dp_r[ifc.addrR] <= ifc.sd ? alu_y : (ifc.sb ? b_reg : 64'd0);
    end

    // Reference architectural state.
    logic [63:0] ref_r [32];
    logic [3:0]  ref_flags;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    typedef struct packed {
        logic [4:0]  fs, ar, aa, ab;
        logic [63:0] k;
        logic        s, sd, sb, c0, w, done, err, rdy;
    } snap_t;

    function automatic snap_t snap();
        snap_t x;
        x = '{fs: ifc.fs, ar: ifc.addrR, aa: ifc.addrA, ab: ifc.addrB, k: ifc.k,
              s: ifc.s, sd: ifc.sd, sb: ifc.sb, c0: ifc.c0, w: ifc.w,
              done: ifc.done, err: ifc.err, rdy: ifc.instr_ready};
        return x;
    endfunction

    function automatic logic bus_active();
        return |{ifc.fs, ifc.addrR, ifc.addrA, ifc.addrB, ifc.k, ifc.s, ifc.sd, ifc.sb, ifc.c0, ifc.w};
    endfunction

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rd,
                                       input logic [4:0] rn, input logic [15:0] lo);
        return {op, rd, rn, lo};
    endfunction

    snap_t tr[$];

    // Transfers one instruction and records one snapshot per cycle up to done (bounded).
    task automatic issue(input logic [31:0] ins);
        @(negedge clk);
        check("ready_idle", ifc.instr_ready, 1);
        ifc.instr       = ins;
        ifc.instr_valid = 1'b1;
        @(negedge clk);
        tr.delete();
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge clk);
            tr.push_back(snap());
            if (ifc.done) begin
                ifc.instr_valid = 1'b0;
                break;
            end
            ifc.instr_valid = 1'($urandom_range(0, 1));
            ifc.instr       = $urandom();
        end
        ifc.instr_valid = 1'b0;
        check("done_seen", tr[$].done, 1);
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < 32; i++) check($sformatf("%s_r%0d", tag, i), dp_r[i], ref_r[i]);
        check({tag, "_flags"}, ifc.flags, ref_flags);
    endtask

    task automatic run(input logic [31:0] ins, input string tag);
        logic [5:0]  op;
        logic [4:0]  rd, rn, rm, efs;
        logic [15:0] imm;
        logic [63:0] a, b, iz, d, t;
        logic        bad, ew, esd, esb, es, ec0, use_a, use_b;
        logic [4:0]  swp_r [3];
        logic [4:0]  swp_b [3];
        int          n_rdy, n_both, n_w;
        snap_t       e;
        op  = ins[31:26]; rd = ins[25:21]; rn = ins[20:16]; rm = ins[15:11]; imm = ins[15:0];
        bad = (op > 6'h0B) || (op == 6'h09 && (rd == SCR || rn == SCR));
        issue(ins);
        check({tag, "_latency"}, 64'(tr.size()), bad ? 1 : (op == 6'h09 ? 4 : 2));
        check({tag, "_err"}, tr[$].err, bad);
        check({tag, "_done_bus_idle"}, bus_active(), 0);
        n_rdy = 0; n_both = 0; n_w = 0;
        foreach (tr[i]) begin
            n_rdy  += int'(tr[i].rdy);
            n_both += int'(tr[i].sd & tr[i].sb);
            n_w    += int'(tr[i].w);
        end
        check({tag, "_busy_ready"}, 64'(n_rdy), 0);
        check({tag, "_sd_sb_both"}, 64'(n_both), 0);
        if (bad) begin
            check({tag, "_no_write"}, 64'(n_w), 0);
        end else if (op == 6'h09 && tr.size() >= 3) begin
            swp_r[0] = SCR; swp_r[1] = rd; swp_r[2] = rn;
            swp_b[0] = rd;  swp_b[1] = rn; swp_b[2] = SCR;
            for (int i = 0; i < 3; i++) begin
                check($sformatf("%s_swp%0d_w_sb_sd", tag, i + 1), {tr[i].w, tr[i].sb, tr[i].sd}, 3'b110);
                check($sformatf("%s_swp%0d_addrR", tag, i + 1), tr[i].ar, swp_r[i]);
                check($sformatf("%s_swp%0d_addrB", tag, i + 1), tr[i].ab, swp_b[i]);
            end
        end else if (op != 6'h09) begin
            e     = tr[0];
            ew    = (op >= 6'h01 && op <= 6'h08) || op == 6'h0B;
            esd   = (op >= 6'h01 && op <= 6'h07) || op == 6'h0B;
            esb   = (op == 6'h08);
            es    = (op == 6'h06 || op == 6'h07 || op == 6'h0B);
            ec0   = (op == 6'h02 || op == 6'h07 || op == 6'h0A);
            use_a = (op >= 6'h01 && op <= 6'h07) || op == 6'h0A;
            use_b = (op >= 6'h01 && op <= 6'h05) || op == 6'h08 || op == 6'h0A;
            case (op)
                6'h01, 6'h06:         efs = 5'h08;
                6'h02, 6'h07, 6'h0A:  efs = 5'h09;
                6'h03:                efs = 5'h00;
                6'h04:                efs = 5'h04;
                6'h05:                efs = 5'h0C;
                default:              efs = 5'h10;
            endcase
            check({tag, "_w_sd_sb_s_c0"}, {e.w, e.sd, e.sb, e.s, e.c0}, {ew, esd, esb, es, ec0});
            if (esd || op == 6'h0A) check({tag, "_fs"}, e.fs, efs);
            if (ew)    check({tag, "_addrR"}, e.ar, rd);
            if (use_a) check({tag, "_addrA"}, e.aa, rn);
            if (use_b) check({tag, "_addrB"}, e.ab, rm);
            if (es)    check({tag, "_k"}, e.k, {48'd0, imm});
        end
        // Architectural effect computed straight from the instruction semantics.
        a = ref_r[rn]; b = ref_r[rm]; iz = {48'd0, imm};
        if (!bad) begin
            case (op)
                6'h01: ref_r[rd] = a + b;
                6'h02: ref_r[rd] = a - b;
                6'h03: ref_r[rd] = a & b;
                6'h04: ref_r[rd] = a | b;
                6'h05: ref_r[rd] = a ^ b;
                6'h06: ref_r[rd] = a + iz;
                6'h07: ref_r[rd] = a - iz;
                6'h08: ref_r[rd] = b;
                6'h09: begin
                    t = ref_r[rd];
                    ref_r[SCR] = t;
                    ref_r[rd]  = ref_r[rn];
                    ref_r[rn]  = t;
                end
                6'h0A: begin
                    d = a - b;
                    ref_flags = {(a[63] != b[63]) && (d[63] != a[63]), a >= b, d[63], d == 64'd0};
                end
                6'h0B: ref_r[rd] = iz;
                default: ;
            endcase
        end
        check_regs(tag);
    endtask

    logic [63:0] old2, old3;
    logic [5:0]  rop;

    initial begin
        ifc.instr       = '0;
        ifc.instr_valid = 1'b0;
        ref_flags       = '0;

        // Reset held for two cycles.
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", ifc.instr_ready, 1);
        check("rst_bus_idle", bus_active(), 0);
        check("rst_flags", ifc.flags, 0);
        check("rst_done_err", {ifc.done, ifc.err}, 2'b00);
        rst = 1'b1;

        // Load every register through LDI so bench datapath and model start equal.
        for (int i = 0; i < 32; i++) begin
            ref_r[i] = 64'hx;
            run(mk(OP_LDI, 5'(i), 5'($urandom), 16'($urandom)), $sformatf("ldi%0d", i));
        end
        run(mk(OP_LDI, 5'd1, 5'd0, 16'd5), "ldi_r1");
        run(mk(OP_LDI, 5'd2, 5'd0, 16'd3), "ldi_r2");

        run(mk(OP_ADD, 5'd4, 5'd1, {5'd2, 11'd0}), "add");
        check("add_r4_is_8", dp_r[4], 64'd8);
        run(mk(OP_SUBI, 5'd6, 5'd1, 16'h0007), "subi");
        check("subi_r6", dp_r[6], 64'hFFFF_FFFF_FFFF_FFFE);
        run(mk(OP_CMP, 5'd0, 5'd1, {5'd1, 11'd0}), "cmp_eq");
        check("cmp_eq_z", ifc.flags[0], 1'b1);
        run(mk(OP_ADD, 5'd7, 5'd1, {5'd2, 11'd0}), "add_after_cmp");
        check("flags_held_z", ifc.flags[0], 1'b1);

        run(mk(OP_LDI, 5'd2, 5'd0, 16'h00AA), "ldi_aa");
        run(mk(OP_LDI, 5'd3, 5'd0, 16'h0055), "ldi_55");
        run(mk(OP_SWP, 5'd2, 5'd3, 16'd0), "swp");
        check("swp_r2", dp_r[2], 64'h55);
        check("swp_r3", dp_r[3], 64'hAA);
        run(mk(OP_SWP, 5'd5, 5'd5, 16'd0), "swp_same");

        run(mk(6'h3F, 5'd1, 5'd2, 16'hFFFF), "illegal_op");
        run(mk(OP_SWP, 5'd27, 5'd3, 16'd0), "swp_scr_rd");
        run(mk(OP_SWP, 5'd4, 5'd27, 16'd0), "swp_scr_rn");
        run(mk(OP_NOP, 5'd9, 5'd1, 16'h1234), "nop");
        run(mk(OP_MOV, 5'd8, 5'd0, {5'd3, 11'd0}), "mov");

        // Random stream including illegal opcodes and scratch-register conflicts.
        for (int i = 0; i < 150; i++) begin
            rop = ($urandom_range(0, 15) <= 11) ? 6'($urandom_range(0, 11)) : 6'($urandom_range(12, 63));
            run(mk(rop, 5'($urandom), 5'($urandom), 16'($urandom)), $sformatf("rnd%0d_op%0h", i, rop));
        end

        // Reset during SWP2 aborts the swap before SWP3 writes rn.
        run(mk(OP_LDI, 5'd2, 5'd0, 16'h1111), "ldi_abort2");
        run(mk(OP_LDI, 5'd3, 5'd0, 16'h2222), "ldi_abort3");
        old2 = ref_r[2];
        old3 = ref_r[3];
        @(negedge clk);
        ifc.instr       = mk(OP_SWP, 5'd2, 5'd3, 16'd0);
        ifc.instr_valid = 1'b1;
        @(negedge clk);
        ifc.instr_valid = 1'b0;
        check("abort_swp1_addrR", ifc.addrR, SCR);
        @(negedge clk);
        check("abort_swp2_addrR", ifc.addrR, 5'd2);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check("abort_bus_idle", bus_active(), 0);
        check("abort_ready", ifc.instr_ready, 1);
        check("abort_done_err", {ifc.done, ifc.err}, 2'b00);
        repeat (3) @(negedge clk);
        ref_r[SCR] = old2;
        ref_r[2]   = old3;
        ref_flags  = '0;
        check("abort_r3_kept", dp_r[3], old3);
        check_regs("abort");
        run(mk(OP_ADD, 5'd10, 5'd2, {5'd3, 11'd0}), "add_after_abort");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ctrl_sequencer.md
Name: ctrl_sequencer

Overview:
- Multi-cycle control unit that drives the control word of the alu_reg datapath (fs, addrR/A/B, k, s, sd, sb, c0, w).
- Accepts one 32-bit instruction per valid/ready handshake and sequences it over 1–3 execute cycles.
- Latches ALU status on compare and reports completion/error.
- Sits between the instruction source (test harness or fetch) and the datapath.

Parameters:
SCR_REG, 5'd27, scratch register index reserved for SWP
K_WIDTH, 64, width of the constant output k (matches datapath)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-low reset
instr  input  32  instruction; fields [31:26] op, [25:21] rd, [20:16] rn, [15:11] rm, [15:0] imm16
instr_valid  input  1  instr is valid this cycle
instr_ready  output  1  sequencer can accept an instruction
status  input  4  ALU status {V,C,N,Z} from datapath
fs  output  5  ALU function select
addrR  output  5  write address
addrA  output  5  A read address
addrB  output  5  B read address
k  output  64  constant to B mux
s  output  1  B mux select (1 = k)
sd  output  1  ALU result onto data bus
sb  output  1  dataB onto data bus
c0  output  1  ALU carry in
w  output  1  register file write enable
flags  output  4  status latched by last CMP
done  output  1  one-cycle pulse, instruction retired
err  output  1  one-cycle pulse, illegal instruction or SCR_REG conflict

Behaviour:
- Reset: the reset condition is rst==0 sampled at a clk edge.
  - State → IDLE.
  - All control outputs (fs, addr*, k, s, sd, sb, c0, w) = 0; flags = 0; done = err = 0; instr_ready = 1 from the first cycle after reset.
  - A reset mid-sequence aborts the sequence immediately; no further writes occur.
- Control outputs are a combinational function of the state register and the latched instruction register (ir).
  - In IDLE and DONE, all control outputs are 0, so the bus is released.
  - sd and sb are never both 1.
- Handshake:
  - instr_ready = 1 only in IDLE.
  - Transfer occurs on a clk edge with instr_valid & instr_ready; ir <= instr.
  - instr_valid while not ready is ignored; instr need not be held.
- States: IDLE, EXEC, SWP1, SWP2, SWP3, DONE.
  - IDLE → EXEC on transfer. Exception: op = SWP goes to SWP1.
  - EXEC → DONE.
  - SWP1 → SWP2 → SWP3 → DONE.
  - DONE → IDLE, with done = 1 in DONE.
  - Latency: transfer edge T → done high in cycle T+2 for single-step ops, T+4 for SWP.
- Opcodes and EXEC control words. All EXEC writes use addrR = rd.
  - 0x01 ADD: fs = FS_ADD, A = rn, B = rm, sd = 1, w = 1.
  - 0x02 SUB: fs = FS_SUB, c0 = 1, otherwise as ADD.
  - 0x03 AND, 0x04 ORR, 0x05 EOR: corresponding FS_ code, otherwise as ADD.
  - 0x06 ADDI / 0x07 SUBI: as ADD/SUB with s = 1 and k = zero-extended imm16.
  - 0x08 MOV: B = rm, sb = 1, w = 1, sd = 0.
  - 0x0A CMP: as SUB but w = 0 and sd = 0. flags <= status at the end of EXEC; flags are otherwise held.
  - 0x0B LDI: fs = FS_PASSB, s = 1, k = imm16 zero-extended, sd = 1, w = 1.
  - 0x00 NOP: EXEC with w = 0.
- SWP rd, rn (0x09), three steps, each with w = 1 and sb = 1:
  - SWP1: addrB = rd, addrR = SCR_REG.
  - SWP2: addrB = rn, addrR = rd.
  - SWP3: addrB = SCR_REG, addrR = rn.
  - rd == rn: all three steps still execute; the value is unchanged.
- Error cases:
  - Any other opcode, or SWP with rd or rn == SCR_REG, goes IDLE → DONE with no write.
  - err and done are both pulsed in DONE, and flags are unchanged.
- No datapath register other than rd (and, for SWP, SCR_REG and rn) is ever written.

Decomposition:
- Package ctrl_pkg holds:
  - Opcode constants OP_NOP..OP_LDI.
  - ALU codes FS_AND = 5'h00, FS_ORR = 5'h04, FS_ADD = 5'h08, FS_SUB = 5'h09, FS_EOR = 5'h0C, FS_PASSB = 5'h10.
  - The state enum.
  - Instruction field bit positions.
- One sub-module, ctrl_decode: combinational, (state, ir) → control word. The FSM and registers live in the top.

Test Plan:
- After reset (rst = 0 for 2 cycles), R1 = 5, R2 = 3; ADD rd = 4, rn = 1, rm = 2 → in EXEC fs = 5'h08, sd = 1, w = 1, addrR = 4; R4 = 8; done at T+2; instr_ready low at T+1 and T+2.
- SUBI rd = 6, rn = 1, imm16 = 0x0007 with R1 = 5 → s = 1, c0 = 1, k = 64'h7; R6 = 64'hFFFF_FFFF_FFFF_FFFE.
- CMP rn = 1, rm = 1 (equal) → w = 0 throughout; flags Z bit = 1; R0–R31 unchanged; a following ADD leaves flags unchanged.
- SWP rd = 2, rn = 3 with R2 = 0xAA, R3 = 0x55 → three cycles with w = 1 and sb = 1 (addrR 27, 2, 3); R2 = 0x55, R3 = 0xAA; done at T+4.
- Opcode 0x3F, then SWP rd = 27 → each gives err = done = 1 in one cycle and w never asserted.
- rst low during SWP2 → next cycle all control outputs 0; R3 not written; instr_ready = 1; a new ADD then completes normally.
